// File: rtl/cpu_types_pkg.sv
// Shared MIPS control types: opcode/funct constants, sequencer states and
// the instruction-class decode used by the multicycle sequencer.
package cpu_types_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;

    localparam opcode_t RTYPE = 6'h00;
    localparam opcode_t J     = 6'h02;
    localparam opcode_t JAL   = 6'h03;
    localparam opcode_t BEQ   = 6'h04;
    localparam opcode_t BNE   = 6'h05;
    localparam opcode_t ADDI  = 6'h08;
    localparam opcode_t ADDIU = 6'h09;
    localparam opcode_t SLTI  = 6'h0A;
    localparam opcode_t SLTIU = 6'h0B;
    localparam opcode_t ANDI  = 6'h0C;
    localparam opcode_t ORI   = 6'h0D;
    localparam opcode_t XORI  = 6'h0E;
    localparam opcode_t LUI   = 6'h0F;
    localparam opcode_t LW    = 6'h23;
    localparam opcode_t SW    = 6'h2B;
    localparam opcode_t HALT  = 6'h3F;

    localparam funct_t JR = 6'h08;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_DECODE,
        SEQ_EXEC,
        SEQ_MEM,
        SEQ_WB,
        SEQ_HALT
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_BEQ,
        CLS_BNE,
        CLS_JUMP,
        CLS_JAL,
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU
    } instr_class_t;

    // Anything not recognised here falls through to NOP so the PC still advances.
    function automatic instr_class_t classify(input opcode_t op, input funct_t fn);
        instr_class_t cls;
        case (op)
            RTYPE:   cls = (fn == JR) ? CLS_JUMP : CLS_ALU;
            J:       cls = CLS_JUMP;
            JAL:     cls = CLS_JAL;
            BEQ:     cls = CLS_BEQ;
            BNE:     cls = CLS_BNE;
            LW:      cls = CLS_LOAD;
            SW:      cls = CLS_STORE;
            ADDI, ADDIU, SLTI, SLTIU,
            ANDI, ORI, XORI, LUI:
                     cls = CLS_ALU;
            default: cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Bundle of the sequencer's control/status wires, with the sequencer side
// (seq) and the environment side (tb) views.
interface datapath_sequencer_if (input logic CLK);
    logic        RST;
    logic [5:0]  InstrOp;
    logic [5:0]  InstrFunc;
    logic        Equal;
    logic        ihit;
    logic        dhit;
    logic        iREN;
    logic        dREN;
    logic        dWEN;
    logic        InstrWEN;
    logic        PcWEN;
    logic        BranchTaken;
    logic        regWEN;
    logic        Halt;
    logic        Fault;
    logic [2:0]  State;
    logic [31:0] InstrCount;

    modport seq (
        input  CLK, RST, InstrOp, InstrFunc, Equal, ihit, dhit,
        output iREN, dREN, dWEN, InstrWEN, PcWEN, BranchTaken, regWEN,
               Halt, Fault, State, InstrCount
    );

    modport tb (
        input  CLK, iREN, dREN, dWEN, InstrWEN, PcWEN, BranchTaken, regWEN,
               Halt, Fault, State, InstrCount,
        output RST, InstrOp, InstrFunc, Equal, ihit, dhit
    );
endinterface

// File: rtl/seq_wait_timer.sv
// Memory wait counter: counts cycles spent waiting for a hit and flags the
// cycle on which the TIMEOUT-th miss occurs.
module seq_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic hit,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Any cycle outside a wait state, or a hit, rearms the counter for the next request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!waiting || hit) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign expired = waiting && !hit && (wait_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/datapath_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Define SEQ_TIMEOUT_EN to build the memory-wait timeout and Fault flag.
module datapath_sequencer
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  InstrOp,
    input  logic [5:0]  InstrFunc,
    input  logic        Equal,
    input  logic        ihit,
    input  logic        dhit,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        InstrWEN,
    output logic        PcWEN,
    output logic        BranchTaken,
    output logic        regWEN,
    output logic        Halt,
    output logic        Fault,
    output logic [2:0]  State,
    output logic [31:0] InstrCount
);
    seq_state_t   state;
    seq_state_t   state_next;
    instr_class_t cls;
    logic         expired;
    logic         halt_q;
    logic [31:0]  count_q;

    // The instruction register holds InstrOp/InstrFunc stable from DECODE to WB.
    assign cls = classify(InstrOp, InstrFunc);

`ifdef SEQ_TIMEOUT_EN
    logic waiting;
    logic hit;
    logic fault_q;

    assign waiting = (state == SEQ_FETCH) || (state == SEQ_MEM);
    assign hit     = (state == SEQ_FETCH) ? ihit : dhit;

    seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (CLK),
        .rst     (RST),
        .waiting (waiting),
        .hit     (hit),
        .expired (expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fault_q <= 1'b0;
        end else if (expired) begin
            fault_q <= 1'b1;
        end
    end

    assign Fault = fault_q;
`else
    logic unused_cfg;

    assign expired    = 1'b0;
    assign Fault      = 1'b0;
    assign unused_cfg = (TIMEOUT == 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are Mealy outputs so a zero-wait hit completes in the request cycle.
    always_comb begin
        state_next  = state;
        iREN        = 1'b0;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        InstrWEN    = 1'b0;
        PcWEN       = 1'b0;
        BranchTaken = 1'b0;
        regWEN      = 1'b0;
        case (state)
            SEQ_IDLE: begin
                state_next = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    InstrWEN   = 1'b1;
                    state_next = SEQ_DECODE;
                end else if (expired) begin
                    state_next = SEQ_HALT;
                end
            end
            SEQ_DECODE: begin
                state_next = (InstrOp == HALT) ? SEQ_HALT : SEQ_EXEC;
            end
            SEQ_EXEC: begin
                case (cls)
                    CLS_BEQ: begin
                        PcWEN       = 1'b1;
                        BranchTaken = Equal;
                        state_next  = SEQ_FETCH;
                    end
                    CLS_BNE: begin
                        PcWEN       = 1'b1;
                        BranchTaken = !Equal;
                        state_next  = SEQ_FETCH;
                    end
                    CLS_JUMP: begin
                        PcWEN       = 1'b1;
                        BranchTaken = 1'b1;
                        state_next  = SEQ_FETCH;
                    end
                    CLS_JAL, CLS_ALU: begin
                        state_next = SEQ_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_next = SEQ_MEM;
                    end
                    default: begin
                        PcWEN      = 1'b1;
                        state_next = SEQ_FETCH;
                    end
                endcase
            end
            SEQ_MEM: begin
                if (cls == CLS_STORE) begin
                    dWEN = 1'b1;
                end else begin
                    dREN = 1'b1;
                end
                if (dhit) begin
                    if (cls == CLS_STORE) begin
                        PcWEN      = 1'b1;
                        state_next = SEQ_FETCH;
                    end else begin
                        state_next = SEQ_WB;
                    end
                end else if (expired) begin
                    state_next = SEQ_HALT;
                end
            end
            SEQ_WB: begin
                regWEN      = 1'b1;
                PcWEN       = 1'b1;
                BranchTaken = (cls == CLS_JAL);
                state_next  = SEQ_FETCH;
            end
            SEQ_HALT: begin
                state_next = SEQ_HALT;
            end
            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt_q <= 1'b0;
        end else if (state_next == SEQ_HALT) begin
            halt_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= 32'd0;
        end else if (PcWEN) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign Halt       = halt_q;
    assign State      = state;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: a responsive memory model feeds
// instructions while a scoreboard checks every PcWEN retirement in order.
module tb_datapath_sequencer;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic        bt;
        logic        rw;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    int   n_tests;
    int   n_fail;
    int   n_issued;
    exp_t sb_q[$];
    exp_t mon_e;
    logic trace_en;
    logic [2:0] trace_q[$];

    datapath_sequencer_if ifc (.CLK(clk));

    datapath_sequencer #(
        .TIMEOUT (4)
    ) dut (
        .CLK         (clk),
        .RST         (ifc.RST),
        .InstrOp     (ifc.InstrOp),
        .InstrFunc   (ifc.InstrFunc),
        .Equal       (ifc.Equal),
        .ihit        (ifc.ihit),
        .dhit        (ifc.dhit),
        .iREN        (ifc.iREN),
        .dREN        (ifc.dREN),
        .dWEN        (ifc.dWEN),
        .InstrWEN    (ifc.InstrWEN),
        .PcWEN       (ifc.PcWEN),
        .BranchTaken (ifc.BranchTaken),
        .regWEN      (ifc.regWEN),
        .Halt        (ifc.Halt),
        .Fault       (ifc.Fault),
        .State       (ifc.State),
        .InstrCount  (ifc.InstrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {ifc.iREN, ifc.dREN, ifc.dWEN, ifc.InstrWEN, ifc.PcWEN, ifc.regWEN, ifc.BranchTaken};
    endfunction

    // Retirement monitor: every PcWEN pulse must match the oldest outstanding instruction.
    always @(negedge clk) begin
        if (trace_en) trace_q.push_back(ifc.State);
        if (!ifc.RST && ifc.PcWEN) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_pcwen", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("branch_taken", {31'd0, ifc.BranchTaken}, {31'd0, mon_e.bt});
                check_val("reg_wen", {31'd0, ifc.regWEN}, {31'd0, mon_e.rw});
                check_val("instr_count_at_retire", ifc.InstrCount, mon_e.cnt);
            end
        end
        if (!ifc.RST && ifc.regWEN && !ifc.PcWEN) check_val("reg_wen_without_pc", 32'd1, 32'd0);
    end

    task automatic do_reset();
        ifc.RST = 1'b1;
        ifc.ihit = 1'b0;
        ifc.dhit = 1'b0;
        ifc.Equal = 1'b0;
        ifc.InstrOp = RTYPE;
        ifc.InstrFunc = 6'h00;
        sb_q.delete();
        n_issued = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_state", {29'd0, ifc.State}, {29'd0, SEQ_IDLE});
        check_val("rst_count", ifc.InstrCount, 32'd0);
        check_val("rst_halt_fault", {30'd0, ifc.Halt, ifc.Fault}, 32'd0);
        check_val("rst_strobes", {25'd0, strobes()}, 32'd0);
        @(posedge clk);
        #1;
        ifc.RST = 1'b0;
    endtask

    // Serve one instruction: fetch with iw wait cycles, then (for LW/SW) data with dw waits.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                         input int iw, input int dw, input logic exp_bt, input logic exp_rw,
                         input logic retires);
        int waited, icnt, rcnt, wcnt;
        logic seen, got, gap;
        exp_t e;
        if (retires) begin
            e.bt = exp_bt;
            e.rw = exp_rw;
            e.cnt = n_issued;
            sb_q.push_back(e);
            n_issued++;
        end
        waited = 0; icnt = 0; seen = 1'b0; got = 1'b0; gap = 1'b0;
        for (int g = 0; g < 64 && !got && !gap; g++) begin
            ifc.ihit = (waited == iw);
            @(negedge clk);
            if (ifc.iREN) begin
                seen = 1'b1;
                icnt++;
                if (ifc.ihit) got = 1'b1;
                else waited++;
            end else if (seen) begin
                gap = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        ifc.ihit = 1'b0;
        check_val("iren_continuous", {31'd0, gap}, 32'd0);
        if (!got) begin
            check_val("fetch_completed", 32'd0, 32'd1);
            return;
        end
        check_val("iren_cycles", icnt, 32'(iw + 1));
        ifc.InstrOp = op;
        ifc.InstrFunc = fn;
        ifc.Equal = eq;
        if (op == LW || op == SW) begin
            waited = 0; rcnt = 0; wcnt = 0; got = 1'b0;
            for (int g = 0; g < 64 && !got; g++) begin
                ifc.dhit = (waited == dw);
                @(negedge clk);
                if (ifc.dREN || ifc.dWEN) begin
                    if (ifc.dREN) rcnt++;
                    if (ifc.dWEN) wcnt++;
                    if (ifc.dhit) got = 1'b1;
                    else waited++;
                end
                @(posedge clk);
                #1;
            end
            ifc.dhit = 1'b0;
            check_val("data_completed", {31'd0, got}, 32'd1);
            check_val("dren_cycles", rcnt, (op == LW) ? 32'(dw + 1) : 32'd0);
            check_val("dwen_cycles", wcnt, (op == SW) ? 32'(dw + 1) : 32'd0);
        end
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 40 && sb_q.size() != 0; g++) begin
            @(negedge clk);
            #1;
        end
        check_val("sb_drain", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_trace [5];
        int icnt;
        n_tests = 0;
        n_fail = 0;
        trace_en = 1'b0;
        exp_trace = '{SEQ_IDLE, SEQ_FETCH, SEQ_DECODE, SEQ_EXEC, SEQ_WB};

        // ADD with zero-wait memory, state trace checked.
        do_reset();
        trace_en = 1'b1;
        issue(RTYPE, 6'h20, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        wait_drain();
        trace_en = 1'b0;
        for (int i = 0; i < 5; i++)
            check_val($sformatf("add_trace_%0d", i),
                      (trace_q.size() > i) ? {29'd0, trace_q[i]} : 32'hFFFF_FFFF,
                      {29'd0, exp_trace[i]});
        check_val("add_count", ifc.InstrCount, 32'd1);

        // Mixed program with memory wait states.
        issue(LW,    6'h00, 1'b0, 1, 3, 1'b0, 1'b1, 1'b1);
        issue(ADDI,  6'h00, 1'b0, 2, 0, 1'b0, 1'b1, 1'b1);
        issue(BEQ,   6'h00, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1);
        issue(BEQ,   6'h00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        issue(BNE,   6'h00, 1'b0, 1, 0, 1'b1, 1'b0, 1'b1);
        issue(J,     6'h00, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        issue(RTYPE, JR,    1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        issue(JAL,   6'h00, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1);
        issue(SW,    6'h00, 1'b1, 0, 2, 1'b0, 1'b0, 1'b1);
        issue(6'h3E, 6'h00, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check_val("program_count", ifc.InstrCount, 32'd11);

        // HALT after five instructions; later ihit pulses must be ignored.
        do_reset();
        issue(RTYPE, 6'h25, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        issue(SW,    6'h00, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1);
        issue(BNE,   6'h00, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
        issue(LW,    6'h00, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        issue(ORI,   6'h00, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        issue(HALT,  6'h00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("halt_state", {29'd0, ifc.State}, {29'd0, SEQ_HALT});
        check_val("halt_flag", {31'd0, ifc.Halt}, 32'd1);
        check_val("halt_count", ifc.InstrCount, 32'd5);
        check_val("halt_no_fault", {31'd0, ifc.Fault}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            ifc.ihit = i[0];
            ifc.dhit = i[1];
            @(negedge clk);
            check_val("halt_strobes", {25'd0, strobes()}, 32'd0);
        end
        ifc.ihit = 1'b0;
        ifc.dhit = 1'b0;
        check_val("halt_sticky", {31'd0, ifc.Halt}, 32'd1);
        check_val("halt_count_held", ifc.InstrCount, 32'd5);
        wait_drain();

        // Reset in the middle of a fetch wait, together with an ihit.
        do_reset();
        ifc.ihit = 1'b0;
        for (int g = 0; g < 10 && !ifc.iREN; g++) @(negedge clk);
        check_val("fetch_wait_iren", {31'd0, ifc.iREN}, 32'd1);
        @(posedge clk);
        #1;
        ifc.RST = 1'b1;
        ifc.ihit = 1'b1;
        #1;
        check_val("rst_iren_drop", {31'd0, ifc.iREN}, 32'd0);
        check_val("rst_async_state", {29'd0, ifc.State}, {29'd0, SEQ_IDLE});
        @(posedge clk);
        #1;
        check_val("rst_wins_instrwen", {31'd0, ifc.InstrWEN}, 32'd0);
        ifc.ihit = 1'b0;
        ifc.RST = 1'b0;
        @(negedge clk);
        check_val("post_rst_idle", {29'd0, ifc.State}, {29'd0, SEQ_IDLE});
        @(negedge clk);
        check_val("post_rst_fetch", {29'd0, ifc.State}, {29'd0, SEQ_FETCH});

`ifdef SEQ_TIMEOUT_EN
        // Starved fetch: with TIMEOUT=4 the fourth miss faults the sequencer.
        do_reset();
        issue(RTYPE, 6'h20, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        icnt = 0;
        for (int g = 0; g < 30 && !ifc.Halt; g++) begin
            @(negedge clk);
            if (ifc.iREN) icnt++;
        end
        check_val("timeout_iren_cycles", icnt, 32'd4);
        check_val("timeout_fault", {31'd0, ifc.Fault}, 32'd1);
        check_val("timeout_halt", {31'd0, ifc.Halt}, 32'd1);
        check_val("timeout_count", ifc.InstrCount, 32'd1);
        wait_drain();
`else
        icnt = 0;
        check_val("fault_tied_low", {31'd0, ifc.Fault}, 32'(icnt));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
